simple_dual_port_ram: RTL and testbench

Synchronous simple-dual-port RAM with one write port and one read port, both usable in the same cycle. It adds byte-enable writes, a selectable read latency and read-during-write policy, read-valid signalling, out-of-range address detection, and an optional clear-on-reset sequencer. It is the parametrised successor to the team's single-port synchronous RAM and sits between datapath producers and consumers as a local buffer.

---
 rtl/simple_dual_port_ram.sv | 149 ++++++++++++++
 tb/tb_simple_dual_port_ram.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/simple_dual_port_ram.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | simple_dual_port_ram                                                     |
// | Simple dual-port RAM: byte-enable write port, pipelined read port.       |
// | Optional clear-on-reset sequencer enabled by `define DPRAM_CLEAR_EN.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module simple_dual_port_ram #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 16,
   parameter int RD_LATENCY = 1,
   parameter int RDW_MODE   = 0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    wr_en,
   input  logic [ADDR_WIDTH-1:0]   wr_addr,
   input  logic [DATA_WIDTH-1:0]   wr_data,
   input  logic [DATA_WIDTH/8-1:0] wr_be,
   input  logic                    rd_en,
   input  logic [ADDR_WIDTH-1:0]   rd_addr,
   output logic [DATA_WIDTH-1:0]   rd_data,
   output logic                    rd_valid,
   output logic                    busy,
   output logic                    addr_err
);

   localparam int                  C_NBYTES = DATA_WIDTH / 8;
   localparam logic [ADDR_WIDTH:0] C_DEPTH  = (ADDR_WIDTH + 1)'(DEPTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic                  w_clr_we;
   logic [ADDR_WIDTH-1:0] w_clr_ptr;
   logic                  w_wr_acc, w_wr_in, w_wr_do;
   logic                  w_rd_acc, w_rd_in;
   logic [DATA_WIDTH-1:0] w_rd_old, w_rd_word;
   logic                  r_s1_valid;
   logic [DATA_WIDTH-1:0] r_s1_data;
   logic                  r_err;

`ifdef DPRAM_CLEAR_EN
   typedef enum logic [0:0] {IDLE = 1'b0, CLEAR = 1'b1} state_t;

   localparam logic [ADDR_WIDTH-1:0] C_LAST = ADDR_WIDTH'(DEPTH - 1);

   state_t                r_state, w_state_nxt;
   logic [ADDR_WIDTH-1:0] r_ptr, w_ptr_nxt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= CLEAR;
         r_ptr   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_ptr   <= w_ptr_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_ptr_nxt   = r_ptr;
      w_clr_we    = 1'b0;
      case (r_state)
         CLEAR: begin
            w_clr_we  = ~rst;
            w_ptr_nxt = r_ptr + ADDR_WIDTH'(1);
            if (r_ptr == C_LAST) begin
               w_state_nxt = IDLE;
               w_ptr_nxt   = '0;
            end
         end
         default: ;
      endcase
   end

   assign w_clr_ptr = r_ptr;
   assign busy      = (r_state == CLEAR);
`else
   assign w_clr_we  = 1'b0;
   assign w_clr_ptr = '0;
   assign busy      = 1'b0;
`endif

   assign w_wr_acc = wr_en & ~busy & ~rst;
   assign w_rd_acc = rd_en & ~busy & ~rst;
   assign w_wr_in  = ({1'b0, wr_addr} < C_DEPTH);
   assign w_rd_in  = ({1'b0, rd_addr} < C_DEPTH);
   assign w_wr_do  = w_wr_acc & w_wr_in;
   assign w_rd_old = w_rd_in ? mem[rd_addr] : '0;

   // New-data mode forwards only the enabled bytes of a same-address write.
   always_comb begin
      w_rd_word = w_rd_old;
      if (RDW_MODE == 1 && w_wr_do && w_rd_in && wr_addr == rd_addr) begin
         for (int b = 0; b < C_NBYTES; b++) begin
            if (wr_be[b]) w_rd_word[8*b +: 8] = wr_data[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_clr_we) begin
         mem[w_clr_ptr] <= '0;
      end else if (w_wr_do) begin
         for (int b = 0; b < C_NBYTES; b++) begin
            if (wr_be[b]) mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
         r_s1_data  <= '0;
         r_err      <= 1'b0;
      end else begin
         r_s1_valid <= w_rd_acc;
         if (w_rd_acc) r_s1_data <= w_rd_word;
         r_err <= (w_wr_acc & ~w_wr_in) | (w_rd_acc & ~w_rd_in);
      end
   end

   assign addr_err = r_err;

   generate
      if (RD_LATENCY == 2) begin : g_lat2
         logic                  r_s2_valid;
         logic [DATA_WIDTH-1:0] r_s2_data;
         always_ff @(posedge clk) begin
            if (rst) begin
               r_s2_valid <= 1'b0;
               r_s2_data  <= '0;
            end else begin
               r_s2_valid <= r_s1_valid;
               if (r_s1_valid) r_s2_data <= r_s1_data;
            end
         end
         assign rd_valid = r_s2_valid;
         assign rd_data  = r_s2_data;
      end else begin : g_lat1
         assign rd_valid = r_s1_valid;
         assign rd_data  = r_s1_data;
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_simple_dual_port_ram.sv
`default_nettype none
// Bench for simple_dual_port_ram: two configurations driven in parallel,
// compared every cycle against a word-level model plus literal spot checks.
module tb_simple_dual_port_ram;

   localparam int D0 = 16, D1 = 12;
   localparam int L0 = 1,  L1 = 2;
   localparam int M0 = 0,  M1 = 1;
   localparam int NCYC = 4096;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wr_en = 1'b0, rd_en = 1'b0;
   logic [3:0]  wr_addr = '0, rd_addr = '0;
   logic [31:0] wr_data = '0;
   logic [3:0]  wr_be = '0;

   logic [31:0] rd_data0, rd_data1;
   logic        rd_valid0, rd_valid1, busy0, busy1, addr_err0, addr_err1;

   always #5 clk = ~clk;

   simple_dual_port_ram #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .DEPTH(D0),
                          .RD_LATENCY(L0), .RDW_MODE(M0)) dut0 (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data0),
      .rd_valid(rd_valid0), .busy(busy0), .addr_err(addr_err0));

   simple_dual_port_ram #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .DEPTH(D1),
                          .RD_LATENCY(L1), .RDW_MODE(M1)) dut1 (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data1),
      .rd_valid(rd_valid1), .busy(busy1), .addr_err(addr_err1));

   int vectors = 0;
   int miscompares = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic int dep(input int i); return (i == 0) ? D0 : D1; endfunction
   function automatic int lat(input int i); return (i == 0) ? L0 : L1; endfunction
   function automatic int rdw(input int i); return (i == 0) ? M0 : M1; endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
      return r;
   endfunction

   // Word-level model: memory contents plus a schedule of future read results.
   logic [31:0] mm [2][16];
   bit          sv [2][NCYC];
   logic [31:0] sd [2][NCYC];
   logic [31:0] cur_d [2];
   bit          cur_v [2], cur_e [2];
   int          bcnt [2];
   int          cyc = 0;
   bit          started = 0;
   logic [31:0] m_old, m_res;
   bit          m_rin, m_win, m_racc, m_wacc;

   initial begin
      for (int i = 0; i < 2; i++) begin
         bcnt[i] = 0; cur_d[i] = '0; cur_v[i] = 0; cur_e[i] = 0;
      end
   end

   always @(posedge clk) begin
      cyc++;
      if (rst) started = 1;
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            for (int j = 0; j < 3; j++) sv[i][cyc+j] = 0;
            cur_v[i] = 0; cur_d[i] = '0; cur_e[i] = 0;
`ifdef DPRAM_CLEAR_EN
            bcnt[i] = dep(i);
`endif
         end else begin
            m_wacc = wr_en && bcnt[i] == 0;
            m_racc = rd_en && bcnt[i] == 0;
            m_win  = int'(wr_addr) < dep(i);
            m_rin  = int'(rd_addr) < dep(i);
            if (bcnt[i] > 0) begin
               mm[i][dep(i) - bcnt[i]] = '0;
               bcnt[i]--;
            end
            if (m_racc) begin
               m_old = m_rin ? mm[i][rd_addr] : 32'h0;
               m_res = m_old;
               if (rdw(i) == 1 && m_rin && m_wacc && m_win && wr_addr == rd_addr)
                  m_res = merge(m_old, wr_data, wr_be);
               sv[i][cyc + lat(i) - 1] = 1;
               sd[i][cyc + lat(i) - 1] = m_res;
            end
            if (m_wacc && m_win) mm[i][wr_addr] = merge(mm[i][wr_addr], wr_data, wr_be);
            cur_e[i] = (m_racc && !m_rin) || (m_wacc && !m_win);
            cur_v[i] = sv[i][cyc];
            if (cur_v[i]) cur_d[i] = sd[i][cyc];
         end
      end
   end

   always @(negedge clk) begin
      if (started) begin
         chk("dut0 rd_valid", {31'b0, rd_valid0}, {31'b0, cur_v[0]});
         chk("dut0 rd_data",  rd_data0, cur_d[0]);
         chk("dut0 addr_err", {31'b0, addr_err0}, {31'b0, cur_e[0]});
         chk("dut0 busy",     {31'b0, busy0}, {31'b0, bcnt[0] > 0});
         chk("dut1 rd_valid", {31'b0, rd_valid1}, {31'b0, cur_v[1]});
         chk("dut1 rd_data",  rd_data1, cur_d[1]);
         chk("dut1 addr_err", {31'b0, addr_err1}, {31'b0, cur_e[1]});
         chk("dut1 busy",     {31'b0, busy1}, {31'b0, bcnt[1] > 0});
      end
   end

   task automatic step(input logic we, input logic [3:0] wa, input logic [31:0] wd,
                       input logic [3:0] be, input logic re, input logic [3:0] ra);
      wr_en = we; wr_addr = wa; wr_data = wd; wr_be = be;
      rd_en = re; rd_addr = ra;
      @(negedge clk);
   endtask

   task automatic idle(); step(1'b0, 4'd0, 32'h0, 4'h0, 1'b0, 4'd0); endtask

   task automatic wait_ready(output int n);
      n = 0;
      while ((busy0 || busy1) && n < 100) begin idle(); n++; end
      chk("ready timeout", {31'b0, busy0 || busy1}, 32'h0);
   endtask

   logic [31:0] lit [8];
   int n;

   initial begin
      lit[0] = 32'h00000000; lit[1] = 32'h01010101; lit[2] = 32'h02020202;
      lit[3] = 32'hAA22CC44; lit[4] = 32'h04040404; lit[5] = 32'hFFFF0000;
      lit[6] = 32'h06060606; lit[7] = 32'h07070707;

      rst = 1'b1;
      idle(); idle();
      chk("reset rd_valid0", {31'b0, rd_valid0}, 32'h0);
      chk("reset rd_data1", rd_data1, 32'h0);
      rst = 1'b0;
      wait_ready(n);
`ifdef DPRAM_CLEAR_EN
      chk("clear busy cycles", n, 32'd16);
      for (int a = 0; a < 16; a++) step(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'(a));
      idle(); idle();
`else
      chk("no-clear busy cycles", n, 32'd0);
`endif

      for (int a = 0; a < 16; a++) step(1'b1, 4'(a), 32'(a) * 32'h01010101, 4'hF, 1'b0, 4'd0);
      idle();

      // byte enables
      step(1'b1, 4'd3, 32'hAABBCCDD, 4'hF, 1'b0, 4'd0);
      step(1'b1, 4'd3, 32'h11223344, 4'b0101, 1'b0, 4'd0);
      step(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd3);
      chk("be dut0 data", rd_data0, 32'hAA22CC44);
      chk("be dut0 valid", {31'b0, rd_valid0}, 32'h1);
      chk("be dut1 early valid", {31'b0, rd_valid1}, 32'h0);
      idle();
      chk("be dut1 data", rd_data1, 32'hAA22CC44);
      chk("be dut1 valid", {31'b0, rd_valid1}, 32'h1);

      // read during write, same address
      step(1'b1, 4'd5, 32'h0, 4'hF, 1'b0, 4'd0);
      step(1'b1, 4'd5, 32'hFFFF0000, 4'hC, 1'b1, 4'd5);
      chk("rdw old dut0", rd_data0, 32'h00000000);
      idle();
      chk("rdw new dut1", rd_data1, 32'hFFFF0000);

      // streaming back-to-back reads
      for (int a = 0; a < 8; a++) begin
         step(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'(a));
         chk("stream dut0", rd_data0, lit[a]);
         if (a > 0) begin
            chk("stream dut1 data", rd_data1, lit[a-1]);
            chk("stream dut1 valid", {31'b0, rd_valid1}, 32'h1);
         end
      end
      idle();
      chk("stream dut1 last", rd_data1, lit[7]);
      idle();

      // out of range (dut1 has 12 words)
      step(1'b1, 4'd13, 32'hDEADBEEF, 4'hF, 1'b1, 4'd13);
      chk("oor dut1 err", {31'b0, addr_err1}, 32'h1);
      chk("oor dut0 err", {31'b0, addr_err0}, 32'h0);
      chk("oor dut0 old data", rd_data0, 32'h0D0D0D0D);
      idle();
      chk("oor dut1 err pulse", {31'b0, addr_err1}, 32'h0);
      chk("oor dut1 valid", {31'b0, rd_valid1}, 32'h1);
      chk("oor dut1 data", rd_data1, 32'h0);
      step(1'b1, 4'd14, 32'h12345678, 4'hF, 1'b1, 4'd15);
      chk("oor both err", {31'b0, addr_err1}, 32'h1);
      idle();
      chk("oor both pulse", {31'b0, addr_err1}, 32'h0);
      for (int a = 0; a < 12; a++) step(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'(a));
      idle(); idle();

      // reset one cycle after a read
      step(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd2);
      rst = 1'b1;
      idle();
      chk("rst dut1 valid", {31'b0, rd_valid1}, 32'h0);
      chk("rst dut1 data", rd_data1, 32'h0);
      rst = 1'b0;
      idle();
      chk("rst dut1 no late valid", {31'b0, rd_valid1}, 32'h0);
      wait_ready(n);
`ifdef DPRAM_CLEAR_EN
      chk("reclear busy cycles", n, 32'd15);
`endif
      for (int a = 0; a < 12; a++) step(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'(a));
      idle(); idle(); idle();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
